// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// optional first-word-fall-through read port and sticky overflow/underflow flags.
module sync_fifo_flagged #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     r_en,
  output logic [WIDTH-1:0]         out_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] PTR_INC = (AW+1)'(1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
      $error("sync_fifo_flagged: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end
  endgenerate

  logic [AW:0]      w_ptr;
  logic [AW:0]      r_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_acc;
  logic             rd_acc;

  // Extra wrap bit makes full and empty distinguishable with equal low bits.
  assign count        = w_ptr - r_ptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + PTR_INC;
      if (rd_acc) r_ptr <= r_ptr + PTR_INC;
      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow  <= (overflow  & ~clr_err) | (w_en & full);
      underflow <= (underflow & ~clr_err) | (r_en & empty);
    end
  end

  // NOTE: storage is deliberately left out of reset so it maps onto RAM;
  // the pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[w_ptr[AW-1:0]] <= in_data;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] rd_data;

      always_ff @(posedge clk) begin
        if (rst)         rd_data <= '0;
        else if (rd_acc) rd_data <= mem[r_ptr[AW-1:0]];
      end

      assign out_data = rd_data;
    end else begin : g_fwft_read
      // Head of queue is presented directly; only meaningful while ~empty.
      assign out_data = mem[r_ptr[AW-1:0]];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: registered-read and FWFT instances share stimulus
// and are compared every cycle against a queue-based occupancy/error model.
module tb_sync_fifo_flagged;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             w_en = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             r_en = 1'b0;
  logic             clr_err = 1'b0;

  logic [WIDTH-1:0] out_data0, out_data1;
  logic             full0, empty0, af0, ae0, ovf0, unf0;
  logic             full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]       count0, count1;

  sync_fifo_flagged #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .w_en(w_en), .in_data(in_data), .r_en(r_en),
    .out_data(out_data0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0),
    .clr_err(clr_err)
  );

  sync_fifo_flagged #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .w_en(w_en), .in_data(in_data), .r_en(r_en),
    .out_data(out_data1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: contents as a queue, plus error flags and the registered read word.
  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  logic [WIDTH-1:0] m_out0 = '0;
  logic             cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                            input logic c, input logic rs);
    logic was_full, was_empty;
    if (rs) begin
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_out0 = '0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (r && !was_empty) m_out0 = q.pop_front();
    if (w && !was_full)  q.push_back(d);
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (w && was_full)  m_ovf = 1'b1;
    if (r && was_empty) m_unf = 1'b1;
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, settle.
  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r,
                     input logic c = 1'b0, input logic rs = 1'b0);
    w_en = w; in_data = d; r_en = r; clr_err = c; rst = rs;
    @(posedge clk);
    model_step(w, d, r, c, rs);
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("count0", 32'(count0), 32'(q.size()));
      check("count1", 32'(count1), 32'(q.size()));
      check("empty",  32'(empty0), 32'(q.size() == 0));
      check("full",   32'(full0),  32'(q.size() == DEPTH));
      check("afull",  32'(af0),    32'(q.size() >= AF));
      check("aempty", 32'(ae0),    32'(q.size() <= AE));
      check("flags1", {28'd0, full1, empty1, af1, ae1}, {28'd0, full0 ^ 1'b0 ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0} & 32'h0 | {28'd0, q.size() == DEPTH, q.size() == 0, q.size() >= AF, q.size() <= AE});
      check("ovf",    {30'd0, ovf1, ovf0}, {30'd0, m_ovf, m_ovf});
      check("unf",    {30'd0, unf1, unf0}, {30'd0, m_unf, m_unf});
      check("out0",   32'(out_data0), 32'(m_out0));
      if (q.size() != 0) check("out1_head", 32'(out_data1), 32'(q[0]));
    end
  end

  initial begin
    // Test 1: reset, then fill with 0x01..0x10 and one extra write.
    cyc(0, '0, 0, 0, 1);
    cmp_en = 1'b1;
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_aempty", 32'(ae0), 32'd1);
    check("rst_count", 32'(count0), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 8'(i), 0);
      if (i == 4)  check("ae_after4", 32'(ae0), 32'd1);
      if (i == 5)  check("ae_after5", 32'(ae0), 32'd0);
      if (i == 11) check("af_after11", 32'(af0), 32'd0);
      if (i == 12) check("af_after12", 32'(af0), 32'd1);
    end
    check("full16", {27'd0, full0, count0}, {27'd0, 1'b1, 5'd16});
    cyc(1, 8'hEE, 0);
    check("ovf17", {27'd0, ovf0, count0}, {27'd0, 1'b1, 5'd16});

    // Test 2: drain in order; registered port shows each word after its edge.
    check("fwft_head", 32'(out_data1), 32'h01);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, '0, 1);
      check("rd_order", 32'(out_data0), 32'(i));
    end
    check("empty16", 32'(empty0), 32'd1);
    cyc(0, '0, 1);
    check("unf17", {23'd0, unf0, out_data0}, {23'd0, 1'b1, 8'h10});

    // Test 3: steady count of 8 with concurrent read/write, pointers wrap.
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'($urandom), 1);
      check("steady8", 32'(count0), 32'd8);
    end

    // Test 4: w&r while full drops the write; w&r while empty drops the read.
    for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 0);
    cyc(1, 8'h77, 1);
    check("full_wr", {27'd0, ovf0, count0}, {27'd0, 1'b1, 5'd15});
    for (int i = 0; i < 15; i++) cyc(0, '0, 1);
    cyc(1, 8'h3C, 1);
    check("empty_wr", {27'd0, unf0, count0}, {27'd0, 1'b1, 5'd1});
    cyc(0, '0, 0, 1);
    check("clr_err", {30'd0, ovf0, unf0}, 32'd0);

    // Test 5: fall-through visibility of a single word.
    cyc(0, '0, 0, 0, 1);
    cyc(1, 8'hA5, 0);
    check("fwft_a5", {23'd0, empty1, out_data1}, {23'd0, 1'b0, 8'hA5});
    cyc(0, '0, 1);
    check("fwft_pop", 32'(empty1), 32'd1);

    // Test 6: reset with count=9 and a pending write.
    cyc(0, '0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 8'($urandom), 0);
    check("pre_rst", {27'd0, unf0, count0}, {27'd0, 1'b1, 5'd9});
    cyc(1, 8'h55, 0, 0, 1);
    check("post_rst", {16'd0, empty0, ovf0, unf0, count0, out_data0 == 8'h00},
                      {16'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1});

    // Randomised phases with varying bias to reach both full and empty.
    for (int p = 0; p < 6; p++) begin
      int wp;
      int rp;
      wp = (p % 2 == 0) ? 75 : 30;
      rp = (p % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 150; i++) begin
        cyc($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
            $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
      end
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
